// File: rtl/npu_mem_pkg.sv
// Shared scratchpad constants and the reader control state encoding.
package npu_mem_pkg;

  localparam int NPU_AW        = 16;
  localparam int NPU_DW        = 16;
  localparam int NPU_MEM_DEPTH = 20480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/tdp_addr_gen.sv
// Address/count generator for the stream reader: holds the next-fetch address,
// the stride and the remaining word count, and flags out-of-range addresses.
module tdp_addr_gen
  import npu_mem_pkg::*;
#(
  parameter int AW        = NPU_AW,
  parameter int MEM_DEPTH = NPU_MEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] length,
  input  logic [AW-1:0] stride,
  output logic [AW-1:0] addr,
  output logic          last,
  output logic          illegal
);

  logic [AW-1:0] addr_reg;
  logic [AW-1:0] stride_reg;
  logic [AW-1:0] remaining_reg;

  // Capture the transfer descriptor on load; advance address and count per fetched word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg      <= '0;
      stride_reg    <= '0;
      remaining_reg <= '0;
    end else if (load) begin
      addr_reg      <= base;
      stride_reg    <= stride;
      remaining_reg <= length;
    end else if (step) begin
      addr_reg      <= addr_reg + stride_reg;   // wraps modulo 2^AW by width
      remaining_reg <= remaining_reg - AW'(1);
    end
  end

  assign addr    = addr_reg;
  assign last    = (remaining_reg == AW'(1));
  assign illegal = (32'(addr_reg) >= 32'(MEM_DEPTH));

endmodule

// File: rtl/tdp_stream_reader.sv
// Read-side scratchpad client: fetches a strided run of words through one RAM
// port (combinational read) and streams them out on valid/ready.
module tdp_stream_reader
  import npu_mem_pkg::*;
#(
  parameter int AW        = NPU_AW,
  parameter int DW        = NPU_DW,
  parameter int MEM_DEPTH = NPU_MEM_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  input  logic [AW-1:0] stride,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic          m_last
);

  state_t        state_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          err_reg;
  logic          m_valid_reg;
  logic          m_last_reg;
  logic [DW-1:0] m_data_reg;

  logic          load;
  logic          fetch;
  logic          step;
  logic          gen_last;
  logic          gen_illegal;

  // A descriptor is only taken while idle; any other start is dropped.
  assign load  = (state_reg == IDLE) && start;
  // Fetch whenever the output register is empty or is being emptied this cycle.
  assign fetch = (state_reg == RUN) && (!m_valid_reg || m_ready);
  // An illegal address ends the fetch phase without consuming a word.
  assign step  = fetch && !gen_illegal;

  tdp_addr_gen #(
    .AW        (AW),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .step    (step),
    .base    (base_addr),
    .length  (length),
    .stride  (stride),
    .addr    (mem_addr),
    .last    (gen_last),
    .illegal (gen_illegal)
  );

  // Control FSM together with the stream output register and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      m_valid_reg <= 1'b0;
      m_last_reg  <= 1'b0;
      m_data_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            err_reg <= 1'b0;
            if (length == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (m_valid_reg && m_ready) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
          end
          if (fetch) begin
            if (gen_illegal) begin
              err_reg   <= 1'b1;
              state_reg <= DRAIN;
            end else begin
              m_data_reg  <= mem_dout;
              m_valid_reg <= 1'b1;
              m_last_reg  <= gen_last;
              if (gen_last) begin
                state_reg <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          if (!m_valid_reg || m_ready) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign m_valid = m_valid_reg;
  assign m_last  = m_last_reg;
  assign m_data  = m_data_reg;
  assign mem_we  = 1'b0;
  assign mem_din = '0;

endmodule
